frame_flip_controller: RTL and testbench

- Parametrised N-buffer (double/triple/quad) swap-chain controller between the renderer core and the video scan-out path.
- Hands the renderer a free target buffer and sequences render start/done.
- Queues completed frames and swaps the displayed buffer only on a vsync rising edge, emitting the flip pulse the renderer top exposes today.

---
 rtl/frame_flip_controller.sv | 191 +++++++++++++++++++
 tb/tb_frame_flip_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_flip_controller.sv
// ============================================================================
// Module   : frame_flip_controller
// Purpose  : N-buffer swap-chain controller that sequences renderer frames and
//            flips the displayed buffer on synchronised vsync rising edges.
// Option   : FLIP_DROP_STALE_EN - a flip jumps straight to the newest frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_flip_controller #(
  parameter  int NUM_BUFFERS = 2,
  parameter  int FRAME_CNT_W = 16,
  localparam int IDX_W       = $clog2(NUM_BUFFERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   vsync,
  input  logic                   render_done,
  output logic                   render_start,
  output logic [IDX_W-1:0]       render_buf,
  output logic [IDX_W-1:0]       display_buf,
  output logic                   flip,
  output logic                   busy,
  output logic [IDX_W-1:0]       pending,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef FLIP_DROP_STALE_EN
  ,
  output logic [FRAME_CNT_W-1:0] dropped_count
`endif
);

  localparam logic [IDX_W+1:0] c_NB            = NUM_BUFFERS[IDX_W+1:0];
  localparam logic [IDX_W-1:0] c_PEND_FREE_MAX = IDX_W'(NUM_BUFFERS - 2);
  localparam logic [IDX_W+1:0] c_ONE_W         = (IDX_W+2)'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RENDERING = 2'd1,
    S_STALLED   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_vs_meta;
  logic                   r_vs_sync;
  logic                   r_vs_prev;
  logic [IDX_W-1:0]       r_display_buf;
  logic [IDX_W-1:0]       r_render_buf;
  logic [IDX_W-1:0]       r_pending;
  logic                   r_render_start;
  logic                   r_flip;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic                   w_vs_rise;
  logic                   w_done_ev;
  logic                   w_flip_ev;
  logic                   w_free;
  logic                   w_start;
  logic [IDX_W-1:0]       w_display_nxt;
  logic [IDX_W-1:0]       w_pending_nxt;
  logic [IDX_W-1:0]       w_render_nxt;

  // Ring indices wrap modulo NUM_BUFFERS; inputs are always below 3*NUM_BUFFERS.
  function automatic logic [IDX_W-1:0] mod_n(input logic [IDX_W+1:0] v);
    logic [IDX_W+1:0] t;
    t = v;
    if (t >= c_NB) t = t - c_NB;
    if (t >= c_NB) t = t - c_NB;
    return t[IDX_W-1:0];
  endfunction

  assign w_vs_rise = r_vs_sync & ~r_vs_prev;
  assign w_done_ev = (r_state == S_RENDERING) & render_done;
  assign w_flip_ev = w_vs_rise & (r_pending != '0);

`ifdef FLIP_DROP_STALE_EN
  logic [FRAME_CNT_W-1:0] r_dropped_count;

  // A flip shows the newest completed frame; every older queued one is skipped.
  always_comb begin
    w_display_nxt = r_display_buf;
    w_pending_nxt = r_pending + IDX_W'(w_done_ev);
    if (w_flip_ev) begin
      w_display_nxt = mod_n({2'b00, r_display_buf} + {2'b00, r_pending});
      w_pending_nxt = IDX_W'(w_done_ev);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped_count <= '0;
    end else if (w_flip_ev) begin
      r_dropped_count <= r_dropped_count + FRAME_CNT_W'(r_pending) - FRAME_CNT_W'(1);
    end
  end

  assign dropped_count = r_dropped_count;
`else
  always_comb begin
    w_display_nxt = r_display_buf;
    w_pending_nxt = r_pending;
    if (w_flip_ev) begin
      w_display_nxt = mod_n({2'b00, r_display_buf} + c_ONE_W);
    end
    case ({w_done_ev, w_flip_ev})
      2'b10:   w_pending_nxt = r_pending + IDX_W'(1);
      2'b01:   w_pending_nxt = r_pending - IDX_W'(1);
      default: w_pending_nxt = r_pending;
    endcase
  end
`endif

  assign w_render_nxt = mod_n({2'b00, w_display_nxt} + {2'b00, w_pending_nxt} + c_ONE_W);
  assign w_free       = (w_pending_nxt <= c_PEND_FREE_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_free) begin
          w_state_nxt = S_RENDERING;
          w_start     = 1'b1;
        end
      end
      S_RENDERING: begin
        if (w_done_ev) begin
          if (!enable) begin
            w_state_nxt = S_IDLE;
          end else if (w_free) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = S_STALLED;
          end
        end
      end
      S_STALLED: begin
        // Room only appears through a flip, so start and flip pulse together.
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_free) begin
          w_state_nxt = S_RENDERING;
          w_start     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_vs_meta      <= 1'b0;
      r_vs_sync      <= 1'b0;
      r_vs_prev      <= 1'b0;
      r_display_buf  <= '0;
      r_render_buf   <= IDX_W'(1);
      r_pending      <= '0;
      r_render_start <= 1'b0;
      r_flip         <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_vs_meta      <= vsync;
      r_vs_sync      <= r_vs_meta;
      r_vs_prev      <= r_vs_sync;
      r_display_buf  <= w_display_nxt;
      r_render_buf   <= w_render_nxt;
      r_pending      <= w_pending_nxt;
      r_render_start <= w_start;
      r_flip         <= w_flip_ev;
      if (w_flip_ev) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign render_start = r_render_start;
  assign render_buf   = r_render_buf;
  assign display_buf  = r_display_buf;
  assign flip         = r_flip;
  assign busy         = (r_state == S_RENDERING);
  assign pending      = r_pending;
  assign frame_count  = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_frame_flip_controller.sv
// ============================================================================
// Module   : tb_frame_flip_controller
// Purpose  : Checks three swap-chain controllers (N=2,3,4) against a
//            frame-queue reference model. Honours FLIP_DROP_STALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_flip_controller;

  logic clk = 1'b0;
  logic reset, enable, vsync, render_done;

  always #5 clk = ~clk;

  logic [0:0]  rb2, db2, pd2;
  logic [1:0]  rb3, db3, pd3, rb4, db4, pd4;
  logic        rs2, fl2, bz2, rs3, fl3, bz3, rs4, fl4, bz4;
  logic [15:0] fc2, fc3;
  logic [3:0]  fc4;
`ifdef FLIP_DROP_STALE_EN
  logic [15:0] dc2, dc3;
  logic [3:0]  dc4;
`endif

  frame_flip_controller #(.NUM_BUFFERS(2), .FRAME_CNT_W(16)) u_n2 (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .render_done(render_done),
    .render_start(rs2), .render_buf(rb2), .display_buf(db2), .flip(fl2), .busy(bz2),
    .pending(pd2), .frame_count(fc2)
`ifdef FLIP_DROP_STALE_EN
    , .dropped_count(dc2)
`endif
  );

  frame_flip_controller #(.NUM_BUFFERS(3), .FRAME_CNT_W(16)) u_n3 (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .render_done(render_done),
    .render_start(rs3), .render_buf(rb3), .display_buf(db3), .flip(fl3), .busy(bz3),
    .pending(pd3), .frame_count(fc3)
`ifdef FLIP_DROP_STALE_EN
    , .dropped_count(dc3)
`endif
  );

  frame_flip_controller #(.NUM_BUFFERS(4), .FRAME_CNT_W(4)) u_n4 (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .render_done(render_done),
    .render_start(rs4), .render_buf(rb4), .display_buf(db4), .flip(fl4), .busy(bz4),
    .pending(pd4), .frame_count(fc4)
`ifdef FLIP_DROP_STALE_EN
    , .dropped_count(dc4)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of finished frames in front of the displayed one.
  int nb[3]  = '{2, 3, 4};
  int fcm[3] = '{65536, 65536, 16};
  int m_disp[3], m_pend[3], m_run[3], m_wait[3];
  int m_start[3], m_flip[3], m_fc[3], m_drop[3];
  int h1, h2, h3;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, nb[d], obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0;
    for (int d = 0; d < 3; d++) begin
      m_disp[d] = 0; m_pend[d] = 0; m_run[d] = 0; m_wait[d] = 0;
      m_start[d] = 0; m_flip[d] = 0; m_fc[d] = 0; m_drop[d] = 0;
    end
  endtask

  task automatic model_edge();
    int rise, n, fl, dn, free;
    if (reset) begin
      model_reset();
      return;
    end
    rise = (h2 == 1 && h3 == 0) ? 1 : 0;
    h3 = h2; h2 = h1; h1 = int'(vsync);
    for (int d = 0; d < 3; d++) begin
      n  = nb[d];
      fl = (rise == 1 && m_pend[d] > 0) ? 1 : 0;
      dn = (m_run[d] == 1 && render_done) ? 1 : 0;
`ifdef FLIP_DROP_STALE_EN
      if (fl == 1) begin
        m_drop[d] = (m_drop[d] + m_pend[d] - 1) % fcm[d];
        m_disp[d] = (m_disp[d] + m_pend[d]) % n;
        m_pend[d] = dn;
      end else begin
        m_pend[d] = m_pend[d] + dn;
      end
`else
      m_disp[d] = (m_disp[d] + fl) % n;
      m_pend[d] = m_pend[d] + dn - fl;
`endif
      m_fc[d]    = (m_fc[d] + fl) % fcm[d];
      m_flip[d]  = fl;
      free       = (m_pend[d] <= n - 2) ? 1 : 0;
      m_start[d] = 0;
      if (m_run[d] == 1) begin
        if (dn == 1) begin
          if (!enable) m_run[d] = 0;
          else if (free == 1) m_start[d] = 1;
          else begin m_run[d] = 0; m_wait[d] = 1; end
        end
      end else if (m_wait[d] == 1) begin
        if (!enable) m_wait[d] = 0;
        else if (free == 1) begin m_wait[d] = 0; m_run[d] = 1; m_start[d] = 1; end
      end else if (enable && free == 1) begin
        m_run[d] = 1; m_start[d] = 1;
      end
    end
  endtask

  task automatic check_one(input int d, input logic [31:0] rb, input logic [31:0] db,
                           input logic [31:0] pd, input logic [31:0] bz,
                           input logic [31:0] rs, input logic [31:0] fl,
                           input logic [31:0] fc);
    check("display_buf", d, db, m_disp[d]);
    check("pending", d, pd, m_pend[d]);
    check("render_buf", d, rb, (m_disp[d] + m_pend[d] + 1) % nb[d]);
    check("busy", d, bz, m_run[d]);
    check("render_start", d, rs, m_start[d]);
    check("flip", d, fl, m_flip[d]);
    check("frame_count", d, fc, m_fc[d]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_one(0, rb2, db2, pd2, bz2, rs2, fl2, fc2);
    check_one(1, rb3, db3, pd3, bz3, rs3, fl3, fc3);
    check_one(2, rb4, db4, pd4, bz4, rs4, fl4, fc4);
`ifdef FLIP_DROP_STALE_EN
    check("dropped_count", 0, dc2, m_drop[0]);
    check("dropped_count", 1, dc3, m_drop[1]);
    check("dropped_count", 2, dc4, m_drop[2]);
`endif
  endtask

  initial begin
    int vs_cnt;
    vs_cnt = 0;
    model_reset();
    reset = 1'b1; enable = 1'b0; vsync = 1'b0; render_done = 1'b0;
    repeat (3) tick();

    // First frame, then two completions before any vsync.
    reset = 1'b0; enable = 1'b1;
    repeat (3) tick();
    render_done = 1'b1; tick(); render_done = 1'b0;
    repeat (4) tick();
    render_done = 1'b1; tick(); render_done = 1'b0;
    repeat (4) tick();

    // Three vsync pulses drain the queues.
    repeat (3) begin
      vsync = 1'b1; repeat (3) tick();
      vsync = 1'b0; repeat (6) tick();
    end

    // Reset mid-frame followed by a stale render_done.
    repeat (3) tick();
    reset = 1'b1; tick();
    reset = 1'b0; render_done = 1'b1; tick();
    render_done = 1'b0; repeat (3) tick();

    // Dropping enable while rendering lets the frame finish and queue.
    enable = 1'b0; repeat (2) tick();
    render_done = 1'b1; tick(); render_done = 1'b0;
    repeat (3) tick();
    enable = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (vs_cnt == 0) vs_cnt = int'($urandom_range(4, 14));
      vs_cnt--;
      vsync       = (vs_cnt < 2);
      render_done = ($urandom_range(0, 2) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
